// File: rtl/alu_seq_ctrl_pkg.sv
// Shared definitions for the register-file/ALU command sequencer:
// state encoding, default datapath widths and the protected register address.
package alu_seq_ctrl_pkg;

  // Default datapath geometry
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int OP_W_DEF   = 3;

  // Register 0 is the hard-wired/protected register
  localparam int R0_ADDR = 0;

  // Binary-encoded sequencer states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // True when a write to the given register must be dropped
  function automatic logic wr_blocked(input logic protect_r0, input logic rd_is_r0);
    return protect_r0 & rd_is_r0;
  endfunction

endpackage

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle sequencer for the register-file + ALU datapath.
// Accepts one command per valid/ready handshake, steers read/write addresses
// and the ALU opcode, captures the ALU result/flags and writes the result back.
// Load-immediate commands skip the read/execute phases and write Cmd_Imm directly.
// Every output is a flop so downstream logic sees glitch-free controls.
module alu_seq_ctrl
  import alu_seq_ctrl_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int OP_W       = OP_W_DEF,
  parameter bit PROTECT_R0 = 1'b1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Cmd_Valid,
  output logic              Cmd_Ready,
  input  logic              Cmd_Load,
  input  logic [OP_W-1:0]   Cmd_ALU_OP,
  input  logic [ADDR_W-1:0] Cmd_Rd,
  input  logic [ADDR_W-1:0] Cmd_Ra,
  input  logic [ADDR_W-1:0] Cmd_Rb,
  input  logic [DATA_W-1:0] Cmd_Imm,
  output logic [ADDR_W-1:0] R_Addr_A,
  output logic [ADDR_W-1:0] R_Addr_B,
  output logic [ADDR_W-1:0] Addr,
  output logic              Write_Reg,
  output logic [DATA_W-1:0] W_Data,
  output logic [OP_W-1:0]   ALU_OP,
  input  logic [DATA_W-1:0] ALU_F,
  input  logic              ALU_ZF,
  input  logic              ALU_OF,
  output logic [DATA_W-1:0] Result,
  output logic              ZF,
  output logic              OF,
  output logic              Busy,
  output logic              Done
);

  // State and command/result registers
  state_e              state_q,     state_d;
  logic [ADDR_W-1:0]   ra_q,        ra_d;
  logic [ADDR_W-1:0]   rb_q,        rb_d;
  logic [ADDR_W-1:0]   rd_q,        rd_d;
  logic [OP_W-1:0]     op_q,        op_d;
  logic [DATA_W-1:0]   w_data_q,    w_data_d;
  logic [DATA_W-1:0]   result_q,    result_d;
  logic                zf_q,        zf_d;
  logic                of_q,        of_d;
  logic                write_reg_q, write_reg_d;
  logic                busy_q,      busy_d;
  logic                done_q,      done_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                accept_s;
  logic                rd_is_r0_s;

  // Next-state logic and command handshake
  always_comb begin
    state_d  = state_q;
    accept_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Cmd_Valid && cmd_ready_q) begin
          accept_s = 1'b1;
          state_d  = Cmd_Load ? ST_WRITE : ST_READ;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_READ:  state_d = ST_EXEC;
      ST_EXEC:  state_d = ST_WRITE;
      ST_WRITE: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Command latch, result capture and flag update
  always_comb begin
    ra_d     = ra_q;
    rb_d     = rb_q;
    rd_d     = rd_q;
    op_d     = op_q;
    w_data_d = w_data_q;
    result_d = result_q;
    zf_d     = zf_q;
    of_d     = of_q;
    if (accept_s) begin
      ra_d = Cmd_Ra;
      rb_d = Cmd_Rb;
      rd_d = Cmd_Rd;
      op_d = Cmd_ALU_OP;
      // A load goes straight to WRITE, so its data is staged at accept time
      if (Cmd_Load) begin
        w_data_d = Cmd_Imm;
      end else begin
        w_data_d = w_data_q;
      end
    end else if (state_q == ST_EXEC) begin
      // ALU output settled during READ/EXEC; w_data_q doubles as result register
      w_data_d = ALU_F;
      zf_d     = ALU_ZF;
      of_d     = ALU_OF;
    end else if (state_q == ST_WRITE) begin
      // Result tracks the written value even when the write is suppressed
      result_d = w_data_q;
    end else begin
      result_d = result_q;
    end
  end

  // Output controls computed from the state being entered, so they are flops
  always_comb begin
    rd_is_r0_s  = (rd_d == ADDR_W'(R0_ADDR));
    write_reg_d = (state_d == ST_WRITE) && !wr_blocked(PROTECT_R0, rd_is_r0_s);
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_DONE);
    cmd_ready_d = (state_d == ST_IDLE);
  end

  // State register; reset aborts any command in flight
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Command, result and output registers
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      ra_q        <= {ADDR_W{1'b0}};
      rb_q        <= {ADDR_W{1'b0}};
      rd_q        <= {ADDR_W{1'b0}};
      op_q        <= {OP_W{1'b0}};
      w_data_q    <= {DATA_W{1'b0}};
      result_q    <= {DATA_W{1'b0}};
      zf_q        <= 1'b0;
      of_q        <= 1'b0;
      write_reg_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cmd_ready_q <= 1'b0;
    end else begin
      ra_q        <= ra_d;
      rb_q        <= rb_d;
      rd_q        <= rd_d;
      op_q        <= op_d;
      w_data_q    <= w_data_d;
      result_q    <= result_d;
      zf_q        <= zf_d;
      of_q        <= of_d;
      write_reg_q <= write_reg_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  assign Cmd_Ready = cmd_ready_q;
  assign R_Addr_A  = ra_q;
  assign R_Addr_B  = rb_q;
  assign Addr      = rd_q;
  assign ALU_OP    = op_q;
  assign Write_Reg = write_reg_q;
  assign W_Data    = w_data_q;
  assign Result    = result_q;
  assign ZF        = zf_q;
  assign OF        = of_q;
  assign Busy      = busy_q;
  assign Done      = done_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a small register-file + adder model.
module tb_alu_seq_ctrl;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Cmd_Valid;
  logic        Cmd_Ready;
  logic        Cmd_Load;
  logic [2:0]  Cmd_ALU_OP;
  logic [4:0]  Cmd_Rd, Cmd_Ra, Cmd_Rb;
  logic [31:0] Cmd_Imm;
  logic [4:0]  R_Addr_A, R_Addr_B, Addr;
  logic        Write_Reg;
  logic [31:0] W_Data;
  logic [2:0]  ALU_OP;
  logic [31:0] ALU_F;
  logic        ALU_ZF, ALU_OF;
  logic [31:0] Result;
  logic        ZF, OF, Busy, Done;

  int n_checks = 0;
  int n_errs   = 0;
  int wr_cnt   = 0;
  int done_cnt = 0;
  int w0, d0;

  logic [31:0] rf [0:31] = '{default: 32'h0};
  logic [31:0] op_a, op_b;

  alu_seq_ctrl #(.DATA_W(32), .ADDR_W(5), .OP_W(3), .PROTECT_R0(1'b1)) dut (
    .Clk(Clk), .Reset(Reset),
    .Cmd_Valid(Cmd_Valid), .Cmd_Ready(Cmd_Ready), .Cmd_Load(Cmd_Load),
    .Cmd_ALU_OP(Cmd_ALU_OP), .Cmd_Rd(Cmd_Rd), .Cmd_Ra(Cmd_Ra), .Cmd_Rb(Cmd_Rb),
    .Cmd_Imm(Cmd_Imm),
    .R_Addr_A(R_Addr_A), .R_Addr_B(R_Addr_B), .Addr(Addr),
    .Write_Reg(Write_Reg), .W_Data(W_Data), .ALU_OP(ALU_OP),
    .ALU_F(ALU_F), .ALU_ZF(ALU_ZF), .ALU_OF(ALU_OF),
    .Result(Result), .ZF(ZF), .OF(OF), .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  // Combinational ALU model: add for opcode 3'b010
  always_comb begin
    op_a   = rf[R_Addr_A];
    op_b   = rf[R_Addr_B];
    ALU_F  = (ALU_OP == 3'b010) ? (op_a + op_b) : 32'h0;
    ALU_ZF = (ALU_F == 32'h0);
    ALU_OF = (op_a[31] == op_b[31]) && (ALU_F[31] != op_a[31]);
  end

  // Register file write port and event counters
  always @(posedge Clk) begin
    if (Write_Reg) begin
      rf[Addr] <= W_Data;
      wr_cnt   <= wr_cnt + 1;
    end
    if (Done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic ld, input logic [2:0] op, input logic [4:0] rd,
                      input logic [4:0] ra, input logic [4:0] rb, input logic [31:0] imm);
    Cmd_Load = ld; Cmd_ALU_OP = op; Cmd_Rd = rd; Cmd_Ra = ra; Cmd_Rb = rb; Cmd_Imm = imm;
    Cmd_Valid = 1'b1;
    for (int i = 0; i < 16 && !Cmd_Ready; i++) @(negedge Clk);
    chk("send_ready", {31'b0, Cmd_Ready}, 32'd1);
    @(posedge Clk);
    #1 Cmd_Valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 16 && !Done; i++) @(negedge Clk);
    chk(tag, {31'b0, Done}, 32'd1);
    @(negedge Clk);
  endtask

  initial begin
    Reset = 1'b0; Cmd_Valid = 1'b0; Cmd_Load = 1'b0; Cmd_ALU_OP = 3'd0;
    Cmd_Rd = 5'd0; Cmd_Ra = 5'd0; Cmd_Rb = 5'd0; Cmd_Imm = 32'h0;
    repeat (2) @(negedge Clk);
    // Reset state
    chk("rst_ready", {31'b0, Cmd_Ready}, 32'd0);
    chk("rst_busy",  {31'b0, Busy}, 32'd0);
    chk("rst_wr",    {31'b0, Write_Reg}, 32'd0);
    chk("rst_done",  {31'b0, Done}, 32'd0);
    chk("rst_result", Result, 32'h0);
    chk("rst_flags", {30'b0, ZF, OF}, 32'd0);
    chk("rst_addr",  {17'b0, Addr, R_Addr_A, R_Addr_B}, 32'd0);
    chk("rst_wdata", W_Data, 32'h0);
    Reset = 1'b1;
    @(negedge Clk);
    chk("rel_ready", {31'b0, Cmd_Ready}, 32'd1);
    chk("rel_busy",  {31'b0, Busy}, 32'd0);

    // Load R3 = 5
    send(1'b1, 3'd0, 5'd3, 5'd0, 5'd0, 32'h0000_0005);
    @(negedge Clk);
    chk("ld_wr",    {31'b0, Write_Reg}, 32'd1);
    chk("ld_addr",  {27'b0, Addr}, 32'd3);
    chk("ld_wdata", W_Data, 32'h5);
    chk("ld_busy",  {30'b0, Busy, Cmd_Ready}, 32'd2);
    @(negedge Clk);
    chk("ld_done",  {31'b0, Done}, 32'd1);
    chk("ld_wr_off", {31'b0, Write_Reg}, 32'd0);
    chk("ld_result", Result, 32'h5);
    chk("ld_flags", {30'b0, ZF, OF}, 32'd0);
    @(negedge Clk);
    chk("ld_idle",  {30'b0, Done, Cmd_Ready}, 32'd1);
    chk("ld_rf3",   rf[3], 32'h5);

    // Load R4 = 7, then R5 = R3 + R4
    send(1'b1, 3'd0, 5'd4, 5'd0, 5'd0, 32'h0000_0007);
    wait_done("ld4_done");
    send(1'b0, 3'b010, 5'd5, 5'd3, 5'd4, 32'h0);
    @(negedge Clk);
    chk("rd_addr_a", {27'b0, R_Addr_A}, 32'd3);
    chk("rd_addr_b", {27'b0, R_Addr_B}, 32'd4);
    chk("rd_op",     {29'b0, ALU_OP}, 32'd2);
    chk("rd_wr",     {31'b0, Write_Reg}, 32'd0);
    @(negedge Clk);
    chk("ex_addr",   {22'b0, R_Addr_A, R_Addr_B}, {22'b0, 5'd3, 5'd4});
    chk("ex_wr",     {31'b0, Write_Reg}, 32'd0);
    @(negedge Clk);
    chk("wb_wr",     {31'b0, Write_Reg}, 32'd1);
    chk("wb_addr",   {27'b0, Addr}, 32'd5);
    chk("wb_wdata",  W_Data, 32'd12);
    @(negedge Clk);
    chk("add_done",  {31'b0, Done}, 32'd1);
    chk("add_result", Result, 32'd12);
    chk("add_flags", {30'b0, ZF, OF}, 32'd0);
    @(negedge Clk);
    chk("add_rf5",   rf[5], 32'd12);

    // Signed overflow: R6 = 7FFF_FFFF + 1
    send(1'b1, 3'd0, 5'd1, 5'd0, 5'd0, 32'h7FFF_FFFF);
    wait_done("ld1_done");
    send(1'b1, 3'd0, 5'd2, 5'd0, 5'd0, 32'h0000_0001);
    wait_done("ld2_done");
    send(1'b0, 3'b010, 5'd6, 5'd1, 5'd2, 32'h0);
    repeat (3) @(negedge Clk);
    chk("ovf_wdata", W_Data, 32'h8000_0000);
    chk("ovf_wr",    {26'b0, Write_Reg, Addr}, {26'b0, 1'b1, 5'd6});
    @(negedge Clk);
    chk("ovf_done",  {31'b0, Done}, 32'd1);
    chk("ovf_flags", {30'b0, ZF, OF}, 32'd1);
    chk("ovf_result", Result, 32'h8000_0000);
    @(negedge Clk);

    // Zero flag: R7 = R0 + R0
    send(1'b0, 3'b010, 5'd7, 5'd0, 5'd0, 32'h0);
    repeat (3) @(negedge Clk);
    chk("zf_wr",     {31'b0, Write_Reg}, 32'd1);
    @(negedge Clk);
    chk("zf_flags",  {30'b0, ZF, OF}, 32'd2);
    chk("zf_result", Result, 32'h0);
    @(negedge Clk);

    // Load into R0 is suppressed, flags untouched, Done still pulses
    w0 = wr_cnt; d0 = done_cnt;
    send(1'b1, 3'd0, 5'd0, 5'd0, 5'd0, 32'h0000_0009);
    @(negedge Clk);
    chk("r0ld_wr",   {31'b0, Write_Reg}, 32'd0);
    chk("r0ld_busy", {31'b0, Busy}, 32'd1);
    @(negedge Clk);
    chk("r0ld_done", {31'b0, Done}, 32'd1);
    chk("r0ld_result", Result, 32'h9);
    chk("r0ld_flags", {30'b0, ZF, OF}, 32'd2);
    @(negedge Clk);
    chk("r0ld_nowr", wr_cnt, w0);
    chk("r0ld_dcnt", done_cnt, d0 + 1);
    chk("r0ld_rf0",  rf[0], 32'h0);

    // ALU into R0: no write, but flags still update
    w0 = wr_cnt;
    send(1'b0, 3'b010, 5'd0, 5'd1, 5'd2, 32'h0);
    repeat (3) @(negedge Clk);
    chk("r0alu_wr",  {31'b0, Write_Reg}, 32'd0);
    @(negedge Clk);
    chk("r0alu_done", {31'b0, Done}, 32'd1);
    chk("r0alu_flags", {30'b0, ZF, OF}, 32'd1);
    chk("r0alu_result", Result, 32'h8000_0000);
    @(negedge Clk);
    chk("r0alu_nowr", wr_cnt, w0);

    // Two back-to-back commands with Cmd_Valid held high
    Cmd_Load = 1'b1; Cmd_ALU_OP = 3'd0; Cmd_Rd = 5'd8; Cmd_Ra = 5'd0; Cmd_Rb = 5'd0;
    Cmd_Imm = 32'h11; Cmd_Valid = 1'b1;
    chk("q_ready0", {31'b0, Cmd_Ready}, 32'd1);
    @(posedge Clk);
    #1 Cmd_Rd = 5'd9; Cmd_Imm = 32'h22;
    @(negedge Clk);
    chk("q1_state",  {29'b0, Busy, Cmd_Ready, Write_Reg}, 32'd5);
    chk("q1_addr",   {27'b0, Addr}, 32'd8);
    @(negedge Clk);
    chk("q1_done",   {30'b0, Done, Cmd_Ready}, 32'd2);
    chk("q1_hold",   {27'b0, Addr}, 32'd8);
    @(negedge Clk);
    chk("q_idle",    {29'b0, Busy, Done, Cmd_Ready}, 32'd1);
    @(posedge Clk);
    #1 Cmd_Valid = 1'b0;
    @(negedge Clk);
    chk("q2_wr",     {26'b0, Write_Reg, Addr}, {26'b0, 1'b1, 5'd9});
    chk("q2_wdata",  W_Data, 32'h22);
    @(negedge Clk);
    chk("q2_done",   {31'b0, Done}, 32'd1);
    chk("q2_result", Result, 32'h22);
    @(negedge Clk);
    chk("q_rf8",     rf[8], 32'h11);
    chk("q_rf9",     rf[9], 32'h22);

    // Reset during EXEC aborts the command
    send(1'b0, 3'b010, 5'd10, 5'd3, 5'd4, 32'h0);
    repeat (2) @(negedge Clk);
    w0 = wr_cnt; d0 = done_cnt;
    Reset = 1'b0;
    #1;
    chk("abort_wr",    {31'b0, Write_Reg}, 32'd0);
    chk("abort_busy",  {30'b0, Busy, Cmd_Ready}, 32'd0);
    chk("abort_flags", {30'b0, ZF, OF}, 32'd0);
    chk("abort_result", Result, 32'h0);
    repeat (3) @(negedge Clk);
    Reset = 1'b1;
    repeat (4) @(negedge Clk);
    chk("abort_nowr",  wr_cnt, w0);
    chk("abort_nodone", done_cnt, d0);
    chk("abort_rf10",  rf[10], 32'h0);
    chk("abort_ready", {31'b0, Cmd_Ready}, 32'd1);

    // Normal command after recovery
    send(1'b0, 3'b010, 5'd10, 5'd3, 5'd4, 32'h0);
    repeat (3) @(negedge Clk);
    chk("rec_wr",    {26'b0, Write_Reg, Addr}, {26'b0, 1'b1, 5'd10});
    chk("rec_wdata", W_Data, 32'd12);
    @(negedge Clk);
    chk("rec_done",  {31'b0, Done}, 32'd1);
    chk("rec_result", Result, 32'd12);
    @(negedge Clk);
    chk("rec_rf10",  rf[10], 32'd12);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  // Hard time limit in case the sequence stalls
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Multi-cycle sequencer for the register-file + ALU datapath.
- Accepts one command at a time over a valid/ready handshake and drives the register-file read/write addresses and the ALU opcode.
- Captures the ALU result and flags, then writes the result back to a destination register.
- Also executes load-immediate commands, which write Cmd_Imm straight into a register.

Parameters:
- DATA_W, 32, register and ALU data width.
- ADDR_W, 5, register address width.
- OP_W, 3, ALU opcode width.
- PROTECT_R0, 1, when 1 a write to register 0 is suppressed.

Ports:
- Clk  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Cmd_Valid  in  1  command present.
- Cmd_Ready  out  1  controller can accept a command.
- Cmd_Load  in  1  1 = load immediate, 0 = ALU operation.
- Cmd_ALU_OP  in  OP_W  ALU opcode, forwarded unchanged.
- Cmd_Rd  in  ADDR_W  destination register.
- Cmd_Ra  in  ADDR_W  source register A.
- Cmd_Rb  in  ADDR_W  source register B.
- Cmd_Imm  in  DATA_W  immediate value for load.
- R_Addr_A  out  ADDR_W  register-file read port A address.
- R_Addr_B  out  ADDR_W  register-file read port B address.
- Addr  out  ADDR_W  register-file write address.
- Write_Reg  out  1  register-file write enable.
- W_Data  out  DATA_W  register-file write data.
- ALU_OP  out  OP_W  ALU opcode.
- ALU_F  in  DATA_W  ALU result.
- ALU_ZF  in  1  ALU zero flag.
- ALU_OF  in  1  ALU overflow flag.
- Result  out  DATA_W  last written value.
- ZF  out  1  latched zero flag.
- OF  out  1  latched overflow flag.
- Busy  out  1  command in progress.
- Done  out  1  one-cycle completion pulse.

Behaviour:
- Datapath timing assumed by this block:
  - Register-file reads are combinational.
  - Register-file writes occur on the Clk edge while Write_Reg=1.
  - The ALU is combinational on the read-port data.
- Reset (Reset=0, asynchronous):
  - State goes to IDLE.
  - All address, data, opcode and Result outputs are 0.
  - Write_Reg, Done, Busy, ZF and OF are 0.
  - Cmd_Ready=0 while reset is held, and =1 from the first cycle after release.
- States: IDLE, READ, EXEC, WRITE, DONE (one-hot or binary; encoding lives in the package).
- IDLE:
  - Cmd_Ready=1, Busy=0.
  - A command is accepted when Cmd_Valid=1 and Cmd_Ready=1; all Cmd_* fields are registered on that edge.
  - Next state is WRITE if Cmd_Load=1, otherwise READ.
- READ:
  - R_Addr_A/B drive the latched Ra/Rb; ALU_OP drives the latched opcode.
  - Lasts one cycle, for operand settling; next state is EXEC.
- EXEC:
  - Addresses and opcode are held.
  - At the end of the cycle, ALU_F goes to a result register, and ALU_ZF/ALU_OF go to ZF/OF.
  - Next state is WRITE.
- WRITE:
  - Addr = latched Rd.
  - W_Data = result register for ALU commands, latched Imm for load commands.
  - Write_Reg=1 for exactly this cycle.
  - If PROTECT_R0=1 and Rd=0, Write_Reg stays 0.
  - Result is updated with W_Data at the end of the cycle.
  - Next state is DONE.
- DONE: Done=1 for one cycle; next state is IDLE.
- Latency from the accept edge:
  - ALU command: write edge at +3, Done high in cycle +4.
  - Load command: write edge at +1, Done high in cycle +2.
  - Next accept is possible in the cycle after Done.
- Busy=1 in every state except IDLE; Cmd_Ready is the complement of Busy outside reset.
- Load commands leave ZF/OF unchanged. ALU commands update ZF/OF even when the write is suppressed.
- Cmd_Valid while Busy is ignored; the source must hold the command until it sees Cmd_Ready.
- R_Addr_A/B, ALU_OP and Addr hold their last values in IDLE and DONE; they change only when a new command is accepted.
- Reset mid-command: the command is aborted immediately, Write_Reg drops asynchronously, and the command is never written and never Done.

Decomposition:
- Shared package:
  - State encoding constants.
  - DATA_W/ADDR_W/OP_W defaults.
  - R0 address constant.
- Single module: FSM plus command/result registers. No sub-module is warranted.

Test Plan:
1. Bench ALU model: F = A+B for opcode 3'b010, ZF = (F==0), OF = signed overflow.
2. Reset release, then load Imm=32'h0000_0005 into R3 -> Write_Reg=1 with Addr=3 and W_Data=5 at cycle +1; Done at +2; ZF/OF remain 0.
3. Load R4=7, then ALU op 3'b010 with Ra=3, Rb=4, Rd=5 -> R_Addr_A=3 and R_Addr_B=4 during READ/EXEC; write of 12 to R5 at +3; Result=12, ZF=0, Done at +4.
4. Load R1=32'h7FFF_FFFF, load R2=1, add into R6 -> W_Data=32'h8000_0000, OF=1.
5. PROTECT_R0=1, load Imm=9 into Rd=0 -> Write_Reg never asserts, Result=9, Done still pulses.
6. Hold Cmd_Valid=1 continuously with two queued commands -> the second is accepted only in the IDLE cycle after Done; Cmd_Ready=0 throughout Busy.
7. Assert Reset low during EXEC -> Write_Reg=0, Busy=0, ZF=OF=0, Result=0 immediately; no write observed; the next command after release completes normally.
